// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the default reset vector, the EBREAK encoding and the fetch FSM state type.
package riscv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_1000;
  localparam logic [31:0] EBREAK_INSN      = 32'h0010_0073;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program-counter flop with synchronous active-high reset and load enable.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous active-high reset, loads RESET_VAL
//   en    - load d this cycle; otherwise hold
//   d     - next PC value
//   q     - current PC value
module pc_reg #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  // PC storage: reset wins, then enable-gated load, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: BOOT/RUN/HALT sequencer, next-PC selection and
// retired-instruction counter. The instruction memory is read combinationally.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   stall               - hold pc and counter this cycle
//   pc_src, pc_target   - redirect request and its target address
//   imem_addr, imem_rd  - instruction memory address (= pc) and returned word
//   pc, pc_plus4        - current fetch address and pc + 4
//   instr, instr_valid  - fetched word and its qualifier (RUN only)
//   halted, misaligned  - HALT state indicator and sticky misaligned-target flag
//   retired_count       - number of instructions accepted
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rd,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  output logic            halted,
  output logic            misaligned,
  output logic [31:0]     retired_count
);

  fetch_state_e    state_r;
  fetch_state_e    state_next_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_next_s;
  logic [XLEN-1:0] pc_plus4_s;
  logic            pc_en_s;
  logic            cnt_inc_s;
  logic            set_misaligned_s;
  logic            misaligned_r;
  logic [31:0]     retired_count_r;

  pc_reg #(
    .XLEN      (XLEN),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .en    (pc_en_s),
    .d     (pc_next_s),
    .q     (pc_r)
  );

  // Sequential successor; the add wraps naturally at 2^XLEN.
  assign pc_plus4_s = pc_r + XLEN'(32'd4);

  // Next-state and next-PC selection. Priority in RUN:
  // ebreak > stall > misaligned redirect > redirect > sequential.
  always_comb begin
    state_next_s     = state_r;
    pc_next_s        = pc_plus4_s;
    pc_en_s          = 1'b0;
    cnt_inc_s        = 1'b0;
    set_misaligned_s = 1'b0;
    case (state_r)
      BOOT: begin
        state_next_s = RUN;
      end
      RUN: begin
        if ((imem_rd == XLEN'(EBREAK_INSN)) && !stall) begin
          // ebreak retires but does not advance the PC.
          cnt_inc_s    = 1'b1;
          state_next_s = HALT;
        end else if (stall) begin
          pc_en_s = 1'b0;
        end else if (pc_src && (pc_target[1:0] != 2'b00)) begin
          set_misaligned_s = 1'b1;
          state_next_s     = HALT;
        end else if (pc_src) begin
          pc_next_s = pc_target;
          pc_en_s   = 1'b1;
          cnt_inc_s = 1'b1;
        end else begin
          pc_en_s   = 1'b1;
          cnt_inc_s = 1'b1;
        end
      end
      HALT: begin
        state_next_s = HALT;
      end
      default: begin
        state_next_s = BOOT;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= BOOT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Sticky misaligned-target flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      misaligned_r <= 1'b0;
    end else if (set_misaligned_s) begin
      misaligned_r <= 1'b1;
    end else begin
      misaligned_r <= misaligned_r;
    end
  end

  // Retired-instruction counter, wraps at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_count_r <= 32'd0;
    end else if (cnt_inc_s) begin
      retired_count_r <= retired_count_r + 32'd1;
    end else begin
      retired_count_r <= retired_count_r;
    end
  end

  assign pc            = pc_r;
  assign imem_addr     = pc_r;
  assign pc_plus4      = pc_plus4_s;
  assign instr         = imem_rd;
  assign instr_valid   = (state_r == RUN);
  assign halted        = (state_r == HALT);
  assign misaligned    = misaligned_r;
  assign retired_count = retired_count_r;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_1000, the first fetch address after reset.
REQ-002 SHALL have parameter XLEN, default 32, the address and instruction width.
REQ-003 SHALL have port clk  input  1  as its single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  as a synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  to hold the PC and the counter this cycle.
REQ-006 SHALL have port pc_src  input  1  to take the redirect (branch/jump) target.
REQ-007 SHALL have port pc_target  input  32  as the redirect address.
REQ-008 SHALL have port imem_addr  output  32  as the instruction-memory address (= pc).
REQ-009 SHALL have port imem_rd  input  32  as the instruction word returned combinationally by memory.
REQ-010 SHALL have port pc  output  32  as the current fetch address.
REQ-011 SHALL have port pc_plus4  output  32  as pc + 4, modulo 2^32.
REQ-012 SHALL have port instr  output  32  as imem_rd passed through to decode.
REQ-013 SHALL have port instr_valid  output  1  asserted only in state RUN.
REQ-014 SHALL have port halted  output  1  asserted in state HALT.
REQ-015 SHALL have port misaligned  output  1  as a sticky misaligned-target error flag.
REQ-016 SHALL have port retired_count  output  32  counting instructions accepted.

Function
REQ-017 SHALL implement an FSM with states BOOT, RUN and HALT.
REQ-018 SHALL move BOOT to RUN unconditionally after one cycle, with instr_valid=0 in BOOT and pc=RESET_PC.
REQ-019 SHALL, in RUN, apply next-PC priority per edge: ebreak > stall > misaligned redirect > redirect > sequential.
REQ-020 SHALL detect ebreak as instr == 32'h0010_0073 with stall=0, then count it, hold pc and go to HALT.
REQ-021 SHALL, when stall=1, hold pc and retired_count; pc_src is ignored.
REQ-022 SHALL, on pc_src=1 with pc_target[1:0]!=0, hold pc, set misaligned=1, go to HALT, and not increment the counter.
REQ-023 SHALL, on pc_src=1 with an aligned target, load pc <= pc_target and increment retired_count.
REQ-024 SHALL otherwise load pc <= pc + 4 (0xFFFF_FFFC wraps to 0x0000_0000) and increment retired_count.
REQ-025 SHALL let retired_count wrap from 0xFFFF_FFFF to 0.
REQ-026 SHALL, in HALT, freeze pc and retired_count, ignore stall and pc_src, and leave only on reset.
REQ-027 SHALL drive imem_addr, pc_plus4 and instr combinationally from pc/imem_rd (zero latency); pc[1:0] is not masked.

Reset
REQ-028 SHALL on reset load state=BOOT, pc=RESET_PC, retired_count=0, misaligned=0; outputs then give instr_valid=0, halted=0.
REQ-029 SHALL give reset priority over all other inputs in any state, including mid-HALT and mid-stall.

Structure
REQ-030 SHALL take RESET_PC default, the EBREAK encoding constant and the FSM state enum from shared package riscv_pkg.
REQ-031 SHALL place the PC flop with synchronous reset and enable in sub-module pc_reg; the FSM, next-PC mux and counter stay in fetch_unit.

Verification (memory preloaded at 0x1000: FFC4A303, 0064A423, 0062E233, FE420AE3)
REQ-032 SHALL check reset: release reset -> cycle 0 pc=0x1000, instr_valid=0; cycle 1 instr_valid=1, instr=FFC4A303.
REQ-033 SHALL check sequential fetch: no stall/pc_src -> pc steps 0x1000, 0x1004, 0x1008, 0x100C with the matching instr; retired_count=3 at 0x100C.
REQ-034 SHALL check redirect and stall: at 0x100C, pc_src=1 with pc_target=0x1000 -> next pc=0x1000; then stall=1 for 2 cycles -> pc stays 0x1000 and count unchanged.
REQ-035 SHALL check misalignment: pc_src=1 with pc_target=0x1006 -> halted=1, misaligned=1, pc unchanged; later pc_src pulses have no effect.
REQ-036 SHALL check ebreak: imem_rd=00100073 at 0x1010 -> count increments once, halted=1, pc stays 0x1010.
REQ-037 SHALL check reset mid-operation: reset asserted in HALT -> next edge pc=0x1000, misaligned=0, retired_count=0, state BOOT.
